// File: rtl/hls_core_arbiter.sv
// hls_core_arbiter: round-robin sharing of one ap_ctrl_hs HLS core.
// Optional watchdog enabled by defining HCA_TIMEOUT_EN.
`timescale 1ns/1ps
module hls_core_arbiter #(
  parameter int NREQ    = 4,
  parameter int NUM_W   = 10,
  parameter int RES_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*NUM_W-1:0] req_num,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_vld,
  output logic [RES_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic                  ap_start,
  output logic [NUM_W-1:0]      ap_num,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic [RES_W-1:0]      ap_res,
  input  logic                  ap_res_vld,
  output logic                  core_rst
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2) begin : g_bad_param
    $error("hls_core_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP,
    S_TRST
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_owner;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_rsp_vld;
  logic [NUM_W-1:0] r_num;
  logic [RES_W-1:0] r_data;
  logic             r_start;
  logic             r_seen;

  logic [IW-1:0]    w_win;
  logic [IW:0]      w_sum;
  logic             w_any;
  logic             w_busy;
  logic [NREQ-1:0]  w_win_oh;
  logic [NREQ-1:0]  w_own_oh;
  logic [IW-1:0]    w_ptr_nxt;
  logic [NUM_W-1:0] w_nums [NREQ];

`ifdef HCA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_crst;
  logic          r_tph;
  logic          r_err;
  assign core_rst = r_crst;
  assign rsp_err  = r_err;
`else
  assign core_rst = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_num
    assign w_nums[gi] = req_num[gi*NUM_W +: NUM_W];
  end

  // Scan downward so the nearest set request after the pointer wins.
  always_comb begin
    w_win = r_ptr;
    w_any = 1'b0;
    w_sum = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(NREQ))
        w_sum = w_sum - (IW+1)'(NREQ);
      if (req[w_sum[IW-1:0]]) begin
        w_win = w_sum[IW-1:0];
        w_any = 1'b1;
      end
    end
  end

  assign w_win_oh  = NREQ'(1) << w_win;
  assign w_own_oh  = NREQ'(1) << r_owner;
  assign w_ptr_nxt = (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_busy    = (r_state == S_START) || (r_state == S_WAIT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_owner   <= '0;
      r_gnt     <= '0;
      r_rsp_vld <= '0;
      r_num     <= '0;
      r_data    <= '0;
      r_start   <= 1'b0;
      r_seen    <= 1'b0;
`ifdef HCA_TIMEOUT_EN
      r_tcnt    <= '0;
      r_crst    <= 1'b0;
      r_tph     <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_gnt     <= '0;
      r_rsp_vld <= '0;

      // An early hbits_ap_vld result takes priority over ap_res at done.
      if (w_busy) begin
        if (ap_res_vld) begin
          r_data <= ap_res;
          r_seen <= 1'b1;
        end else if (ap_done && !r_seen) begin
          r_data <= ap_res;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_any && ap_idle) begin
            r_state <= S_START;
            r_gnt   <= w_win_oh;
            r_num   <= w_nums[w_win];
            r_owner <= w_win;
            r_start <= 1'b1;
            r_ptr   <= w_ptr_nxt;
            r_seen  <= 1'b0;
          end
        end
        S_START: begin
          if (ap_ready || ap_done)
            r_start <= 1'b0;
          if (ap_done) begin
            r_state   <= S_RESP;
            r_rsp_vld <= w_own_oh;
          end else if (ap_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ap_done) begin
            r_state   <= S_RESP;
            r_rsp_vld <= w_own_oh;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
`ifdef HCA_TIMEOUT_EN
        S_TRST: begin
          if (r_tph) begin
            r_crst    <= 1'b0;
            r_err     <= 1'b1;
            r_data    <= '0;
            r_rsp_vld <= w_own_oh;
            r_state   <= S_RESP;
          end else begin
            r_tph <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
        end
      endcase

`ifdef HCA_TIMEOUT_EN
      if (w_busy) begin
        r_tcnt <= r_tcnt + 1'b1;
        if (!ap_done && r_tcnt == TW'(TIMEOUT - 1)) begin
          r_state <= S_TRST;
          r_start <= 1'b0;
          r_crst  <= 1'b1;
          r_tph   <= 1'b0;
        end
      end else begin
        r_tcnt <= '0;
      end
      if (r_state == S_RESP)
        r_err <= 1'b0;
`endif
    end
  end

  assign gnt      = r_gnt;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_data;
  assign ap_start = r_start;
  assign ap_num   = r_num;

endmodule
